// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: round-robin sharing of one frame-buffer memory port between two line-segment pixel requesters
module frame_mem_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int PIX_W       = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       img_size_x_i,
  input  logic              r0_go_i,
  input  logic              r0_wr_i,
  input  logic [15:0]       r0_start_x_i,
  input  logic [15:0]       r0_line_i,
  input  logic [15:0]       r0_num_pixels_i,
  input  logic [PIX_W-1:0]  r0_wr_pix_i,
  output logic              r0_wr_stb_o,
  output logic [PIX_W-1:0]  r0_rd_pix_o,
  output logic              r0_rd_stb_o,
  output logic              r0_busy_o,
  output logic              r0_done_o,
  output logic              r0_err_o,
  input  logic              r1_go_i,
  input  logic              r1_wr_i,
  input  logic [15:0]       r1_start_x_i,
  input  logic [15:0]       r1_line_i,
  input  logic [15:0]       r1_num_pixels_i,
  input  logic [PIX_W-1:0]  r1_wr_pix_i,
  output logic              r1_wr_stb_o,
  output logic [PIX_W-1:0]  r1_rd_pix_o,
  output logic              r1_rd_stb_o,
  output logic              r1_busy_o,
  output logic              r1_done_o,
  output logic              r1_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PIX_W-1:0]  mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [PIX_W-1:0]  mem_rdata_i
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, SETUP, REQ, RDWAIT, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [1:0] go, wr_in, pend_q, wr_q, req_v, done, wr_stb, rd_stb_q;
  logic [15:0] sx_in[2], ln_in[2], np_in[2], sx_q[2], ln_q[2], np_q[2];
  logic [PIX_W-1:0] wr_pix[2], rd_pix_q[2];
  logic owner_q, owner_d, rr_q, rr_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;
  assign go     = {r1_go_i, r0_go_i};
  assign wr_in  = {r1_wr_i, r0_wr_i};
  assign sx_in  = '{r0_start_x_i, r1_start_x_i};
  assign ln_in  = '{r0_line_i, r1_line_i};
  assign np_in  = '{r0_num_pixels_i, r1_num_pixels_i};
  assign wr_pix = '{r0_wr_pix_i, r1_wr_pix_i};
  // a GO arriving while idle competes in the same cycle it is captured
  assign req_v = pend_q | go;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (|req_v) begin
          owner_d = &req_v ? rr_q : req_v[1];
          rr_d    = &req_v ? ~rr_q : rr_q;
          state_d = SETUP;
        end
      end
      SETUP: begin
        addr_d  = ADDR_W'(32'(ln_q[owner_q]) * 32'(img_size_x_i) + 32'(sx_q[owner_q]));
        rem_d   = np_q[owner_q];
        state_d = np_q[owner_q] == 16'd0 ? FIN : REQ;
      end
      REQ, RDWAIT: begin
        if (state_q == REQ ? mem_ack_i : mem_rvalid_i)
          state_d = (state_q == RDWAIT || wr_q[owner_q]) ? NEXT : RDWAIT;
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end else
          tmo_d = tmo_q + TW'(1);
      end
      NEXT: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - 16'd1;
        state_d = rem_q == 16'd1 ? FIN : REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      rd_stb_q    <= '0;
      rd_pix_q[0] <= '0;
      rd_pix_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= req_v & ~done;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      rd_stb_q <= '0;
      if (state_q == RDWAIT && mem_rvalid_i) begin
        rd_pix_q[owner_q] <= mem_rdata_i;
        rd_stb_q[owner_q] <= 1'b1;
      end
    end
  end
  // slot contents are only meaningful while pending, so they need no reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (go[i] && !pend_q[i]) begin
        wr_q[i] <= wr_in[i];
        sx_q[i] <= sx_in[i];
        ln_q[i] <= ln_in[i];
        np_q[i] <= np_in[i];
      end
    end
  end
  assign mem_req_o   = state_q == REQ;
  assign mem_we_o    = mem_req_o & wr_q[owner_q];
  assign mem_wdata_o = mem_we_o ? wr_pix[owner_q] : '0;
  assign mem_addr_o  = addr_q;
  assign done        = {2{state_q == FIN}} & {owner_q, ~owner_q};
  assign wr_stb      = {2{mem_we_o & mem_ack_i}} & {owner_q, ~owner_q};
  assign r0_wr_stb_o = wr_stb[0];
  assign r1_wr_stb_o = wr_stb[1];
  assign r0_rd_pix_o = rd_pix_q[0];
  assign r1_rd_pix_o = rd_pix_q[1];
  assign r0_rd_stb_o = rd_stb_q[0];
  assign r1_rd_stb_o = rd_stb_q[1];
  assign r0_busy_o   = pend_q[0];
  assign r1_busy_o   = pend_q[1];
  assign r0_done_o   = done[0];
  assign r1_done_o   = done[1];
  assign r0_err_o    = done[0] & err_q;
  assign r1_err_o    = done[1] & err_q;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed-vector bench for frame_mem_arbiter with a small memory responder
module tb_frame_mem_arbiter;
  localparam logic [23:0] PIX0 = 24'hC0FFEE;
  localparam logic [23:0] PIX1 = 24'h0BEEF1;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] img_size_x = '0;
  logic r0_go = 0, r0_wr = 0, r1_go = 0, r1_wr = 0;
  logic [15:0] r0_start_x = '0, r0_line = '0, r0_num_pixels = '0;
  logic [15:0] r1_start_x = '0, r1_line = '0, r1_num_pixels = '0;
  logic [23:0] r0_wr_pix = PIX0, r1_wr_pix = PIX1;
  logic r0_wr_stb, r0_rd_stb, r0_busy, r0_done, r0_err;
  logic r1_wr_stb, r1_rd_stb, r1_busy, r1_done, r1_err;
  logic [23:0] r0_rd_pix, r1_rd_pix;
  logic mem_req, mem_we, mem_ack = 1'b1, mem_rvalid = 1'b0;
  logic [23:0] mem_addr, mem_wdata, mem_rdata = '0;
  int n_chk = 0, n_err = 0;
  int rel, busy0_first, busy0_last, req_cnt, req_first, wr0, wr1, done0_at, done1_at, rcnt = 0;
  logic err0, err1, err_nodone, r0_act, r1_act;
  logic [23:0] addrq[$], wdq[$], rd1q[$], rdq[$];

  frame_mem_arbiter #(.ADDR_W(24), .PIX_W(24), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst), .img_size_x_i(img_size_x),
    .r0_go_i(r0_go), .r0_wr_i(r0_wr), .r0_start_x_i(r0_start_x), .r0_line_i(r0_line),
    .r0_num_pixels_i(r0_num_pixels), .r0_wr_pix_i(r0_wr_pix), .r0_wr_stb_o(r0_wr_stb),
    .r0_rd_pix_o(r0_rd_pix), .r0_rd_stb_o(r0_rd_stb), .r0_busy_o(r0_busy),
    .r0_done_o(r0_done), .r0_err_o(r0_err),
    .r1_go_i(r1_go), .r1_wr_i(r1_wr), .r1_start_x_i(r1_start_x), .r1_line_i(r1_line),
    .r1_num_pixels_i(r1_num_pixels), .r1_wr_pix_i(r1_wr_pix), .r1_wr_stb_o(r1_wr_stb),
    .r1_rd_pix_o(r1_rd_pix), .r1_rd_stb_o(r1_rd_stb), .r1_busy_o(r1_busy),
    .r1_done_o(r1_done), .r1_err_o(r1_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // read data returns three cycles after each accepted read request
  initial begin
    forever begin
      @(posedge clk);
      #2;
      mem_rvalid = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdq.pop_front();
        end
      end
      if (mem_req && mem_ack && !mem_we) rcnt = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic outs_or();
    return |{r0_wr_stb, r0_rd_pix, r0_rd_stb, r0_busy, r0_done, r0_err,
             r1_wr_stb, r1_rd_pix, r1_rd_stb, r1_busy, r1_done, r1_err,
             mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic clr();
    rel = 0; busy0_first = -1; busy0_last = -1; req_cnt = 0; req_first = -1;
    wr0 = 0; wr1 = 0; done0_at = -1; done1_at = -1;
    err0 = 0; err1 = 0; err_nodone = 0; r0_act = 0; r1_act = 0;
    addrq.delete(); wdq.delete(); rd1q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
    if (r0_busy) begin
      if (busy0_first < 0) busy0_first = rel;
      busy0_last = rel;
    end
    if (mem_req) begin
      req_cnt++;
      if (req_first < 0) req_first = rel;
    end
    if (mem_req && mem_ack) addrq.push_back(mem_addr);
    if (mem_req && mem_we && mem_ack) wdq.push_back(mem_wdata);
    wr0 += int'(r0_wr_stb);
    wr1 += int'(r1_wr_stb);
    if (r1_rd_stb) rd1q.push_back(r1_rd_pix);
    if (r0_done) begin done0_at = rel; err0 = r0_err; end
    if (r1_done) begin done1_at = rel; err1 = r1_err; end
    err_nodone |= (r0_err & ~r0_done) | (r1_err & ~r1_done);
    r0_act |= r0_wr_stb | r0_rd_stb | r0_done | r0_busy;
    r1_act |= r1_wr_stb | r1_rd_stb | r1_done | r1_busy;
  endtask

  task automatic fire(input logic g0, input logic g1);
    clr();
    r0_go = g0;
    r1_go = g1;
    tick();
    r0_go = 0;
    r1_go = 0;
  endtask

  initial begin
    clr();
    tick();
    tick();
    chk("reset_outputs_zero", 32'(outs_or()), 0);
    rst = 0;
    img_size_x = 16'd640;

    r0_wr = 1; r0_line = 2; r0_start_x = 5; r0_num_pixels = 3;
    fire(1, 0);
    repeat (9) tick();
    chk("wr_busy_rise", busy0_first, 1);
    chk("wr_first_req", req_first, 2);
    chk("wr_num_addr", addrq.size(), 3);
    for (int i = 0; i < 3; i++) chk("wr_addr", 32'(addrq[i]), 1285 + i);
    chk("wr_strobes", wr0, 3);
    chk("wr_wdata", 32'(wdq[0]), 32'(PIX0));
    chk("wr_done_cycle", done0_at, 8);
    chk("wr_err", 32'(err0), 0);
    chk("wr_busy_last", busy0_last, 8);
    chk("wr_r1_quiet", 32'(r1_act), 0);

    rdq.push_back(24'hA5A5A5);
    rdq.push_back(24'h5A5A5A);
    r1_wr = 0; r1_line = 0; r1_start_x = 10; r1_num_pixels = 2;
    fire(0, 1);
    repeat (13) tick();
    chk("rd_num_addr", addrq.size(), 2);
    chk("rd_addr0", 32'(addrq[0]), 10);
    chk("rd_addr1", 32'(addrq[1]), 11);
    chk("rd_num_strobes", rd1q.size(), 2);
    chk("rd_pix0", 32'(rd1q[0]), 32'h00A5A5A5);
    chk("rd_pix1", 32'(rd1q[1]), 32'h005A5A5A);
    chk("rd_no_writes", wdq.size(), 0);
    chk("rd_done_cycle", done1_at, 12);
    chk("rd_r0_quiet", 32'(r0_act), 0);

    r0_wr = 1; r0_line = 1; r0_start_x = 0; r0_num_pixels = 1;
    r1_wr = 1; r1_line = 3; r1_start_x = 7; r1_num_pixels = 1;
    fire(1, 1);
    repeat (10) tick();
    chk("rr1_r0_done", done0_at, 4);
    chk("rr1_r1_done", done1_at, 9);
    chk("rr1_addr0", 32'(addrq[0]), 640);
    chk("rr1_addr1", 32'(addrq[1]), 1927);
    chk("rr1_wdata1", 32'(wdq[1]), 32'(PIX1));
    chk("rr1_strobes", 32'(wr0 * 16 + wr1), 17);
    fire(1, 1);
    repeat (10) tick();
    chk("rr2_r1_done", done1_at, 4);
    chk("rr2_r0_done", done0_at, 9);
    chk("rr2_addr0", 32'(addrq[0]), 1927);

    r0_num_pixels = 0;
    fire(1, 0);
    repeat (4) tick();
    chk("zero_no_req", req_cnt, 0);
    chk("zero_done_cycle", done0_at, 2);
    chk("zero_busy_first", busy0_first, 1);
    chk("zero_busy_last", busy0_last, 2);

    mem_ack = 0;
    r0_line = 0; r0_start_x = 0; r0_num_pixels = 2;
    fire(1, 0);
    repeat (19) tick();
    chk("tmo_req_cycles", req_cnt, 16);
    chk("tmo_done_cycle", done0_at, 18);
    chk("tmo_err", 32'(err0), 1);
    chk("tmo_err_only_with_done", 32'(err_nodone), 0);
    mem_ack = 1;
    r0_start_x = 100; r0_num_pixels = 1;
    fire(1, 0);
    repeat (5) tick();
    chk("post_tmo_done", done0_at, 4);
    chk("post_tmo_err", 32'(err0), 0);
    chk("post_tmo_addr", 32'(addrq[0]), 100);

    r0_line = 1; r0_start_x = 1; r0_num_pixels = 5;
    fire(1, 0);
    repeat (4) tick();
    chk("mid_rst_pixels_before", wr0, 2);
    rst = 1;
    tick();
    chk("mid_rst_outputs_zero", 32'(outs_or()), 0);
    rst = 0;
    repeat (8) tick();
    chk("mid_rst_no_done", done0_at, -1);
    r0_num_pixels = 1; r1_num_pixels = 1;
    fire(1, 1);
    repeat (10) tick();
    chk("post_rst_r0_first", done0_at, 4);
    chk("post_rst_r1_second", done1_at, 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
